spi_master_arbiter: RTL and testbench

- Shares one 32-bit SPI master between NREQ requesters.
- Per transaction: picks a requester, drives the master's ClockDiv/DataIn, issues a one-cycle Start, tracks Busy to completion, then returns the received word with a Done pulse to the winner.
- Sits between the Nios-side register/bridge logic and the SPI master.
- Provides a one-hot select so top level can steer the master's SS_n to per-device chip selects.

---
 rtl/spi_arb_pkg.sv | 24 ++
 rtl/spi_master_arbiter_if.sv | 34 +++
 rtl/spi_arb_picker.sv | 41 ++++
 rtl/spi_master_arbiter.sv | 121 ++++++++++++
 tb/tb_spi_master_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI master arbiter: FSM encoding, SPI word/divider widths,
// watchdog limit and a small modular-add helper used by the round-robin search.
package spi_arb_pkg;

  localparam int SPI_DW   = 32;
  localparam int SPI_DIVW = 8;
  localparam int WD_LIMIT = 4;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t IDLE      = 3'd0;
  localparam arb_state_t START     = 3'd1;
  localparam arb_state_t WAIT_BUSY = 3'd2;
  localparam arb_state_t XFER      = 3'd3;
  localparam arb_state_t DONE      = 3'd4;

  // (a + b) mod n for 0 <= a, b < n
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; the surrounding logic/bench uses master.
interface spi_master_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
);

  logic [NREQ-1:0]          Req;
  logic [NREQ*SPI_DW-1:0]   ReqData;
  logic [NREQ*SPI_DIVW-1:0] ReqDiv;
  logic [NREQ-1:0]          Done;
  logic [SPI_DW-1:0]        RdData;
  logic [NREQ-1:0]          Sel;
  logic [IDX_W-1:0]         GntIdx;
  logic                     ArbBusy;
  logic [SPI_DIVW-1:0]      SpiClockDiv;
  logic                     SpiStart;
  logic [SPI_DW-1:0]        SpiDataIn;
  logic                     SpiBusy;
  logic [SPI_DW-1:0]        SpiDataOut;

  modport slave (
    input  Req, ReqData, ReqDiv, SpiBusy, SpiDataOut,
    output Done, RdData, Sel, GntIdx, ArbBusy, SpiClockDiv, SpiStart, SpiDataIn
  );

  modport master (
    output Req, ReqData, ReqDiv, SpiBusy, SpiDataOut,
    input  Done, RdData, Sel, GntIdx, ArbBusy, SpiClockDiv, SpiStart, SpiDataIn
  );

endinterface

// File: rtl/spi_arb_picker.sv
// Combinational winner selection. Fixed priority (lowest index) by default;
// SPI_ARB_ROUND_ROBIN_EN rotates the search to start at ptr.
module spi_arb_picker
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             valid
);

  logic [NREQ-1:0]  cand;
  logic [IDX_W-1:0] off;

  // Lowest set candidate bit wins
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[k]) off = IDX_W'(k);
    end
  end

  assign valid = |cand;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  // cand[k] is the request k positions after the pointer
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign cand[gi] = req[IDX_W'(wrap_add(int'(ptr), gi, NREQ))];
  end
  assign win = IDX_W'(wrap_add(int'(ptr), int'(off), NREQ));
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign cand       = req;
  assign win        = off;
`endif

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one 32-bit SPI master between NREQ requesters: grant, Start, track Busy, Done.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  spi_master_arbiter_if.slave  bus
);

  localparam int WD_W = $clog2(WD_LIMIT);

  arb_state_t          state_reg;
  logic [IDX_W-1:0]    gnt_reg;
  logic [NREQ-1:0]     sel_reg;
  logic [NREQ-1:0]     done_reg;
  logic [SPI_DW-1:0]   rd_data_reg;
  logic [SPI_DW-1:0]   data_in_reg;
  logic [SPI_DIVW-1:0] div_reg;
  logic [WD_W-1:0]     wd_reg;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win;
  logic                win_valid;
  logic                finish;

  spi_arb_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.Req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_valid)
  );

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_reg <= '0;
    end else if (state_reg == DONE) begin
      ptr_reg <= (int'(gnt_reg) == NREQ - 1) ? '0 : gnt_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;
`else
  assign ptr = '0;
`endif

  // Watchdog: WAIT_BUSY lasts at most WD_LIMIT-1 cycles, so DONE follows Start
  // by no more than WD_LIMIT cycles when the master never raises Busy.
  assign finish = ((state_reg == WAIT_BUSY) && !bus.SpiBusy && (wd_reg == WD_W'(WD_LIMIT - 2)))
               || ((state_reg == XFER) && !bus.SpiBusy);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      sel_reg     <= '0;
      done_reg    <= '0;
      rd_data_reg <= '0;
      data_in_reg <= '0;
      div_reg     <= '0;
      wd_reg      <= '0;
    end else begin
      // RdData and the Done bit are registered on entry to DONE so both are
      // visible together during the DONE cycle.
      if (finish) begin
        rd_data_reg <= bus.SpiDataOut;
        done_reg    <= sel_reg;
        state_reg   <= DONE;
      end

      case (state_reg)
        IDLE: begin
          if (win_valid && !bus.SpiBusy) begin
            gnt_reg     <= win;
            div_reg     <= bus.ReqDiv[int'(win)*SPI_DIVW +: SPI_DIVW];
            data_in_reg <= bus.ReqData[int'(win)*SPI_DW +: SPI_DW];
            sel_reg     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            state_reg   <= START;
          end
        end
        START: begin
          wd_reg    <= '0;
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.SpiBusy) begin
            state_reg <= XFER;
          end else if (!finish) begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        XFER: begin
        end
        DONE: begin
          done_reg  <= '0;
          sel_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Done        = done_reg;
  assign bus.RdData      = rd_data_reg;
  assign bus.Sel         = sel_reg;
  assign bus.GntIdx      = gnt_reg;
  assign bus.ArbBusy     = (state_reg != IDLE);
  assign bus.SpiClockDiv = div_reg;
  assign bus.SpiStart    = (state_reg == START);
  assign bus.SpiDataIn   = data_in_reg;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench: a requester-level model predicts service order and responses,
// a behavioural SPI master stub answers with per-device words chosen by Sel.
module tb_spi_master_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
`ifdef SPI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [7:0]  div;
    logic [31:0] resp;
    bit          wd;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

  spi_master_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cur_valid = 1'b0;
  bit          stable_ok = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = -1000;
  int          dones = 0;
  int          m_ptr = 0;
  logic [31:0] tx_data [NREQ];
  logic [7:0]  tx_div  [NREQ];
  logic [31:0] dev_resp[NREQ];
  bit          stub_mode = 1'b0;
  logic [31:0] stub_word = 32'h0;
  int          sl_cnt = 0;
  bit          sl_pend = 1'b0;
  logic [7:0]  sl_div = 8'h0;
  logic [31:0] sl_resp = 32'h0;

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Behavioural SPI master: Busy rises the cycle after Start, lasts 64*(div+1)
  // cycles, then DataOut shows the word of the device selected by Sel.
  initial begin
    bus.SpiBusy    = 1'b0;
    bus.SpiDataOut = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        bus.SpiBusy = 1'b0;
        sl_cnt      = 0;
        sl_pend     = 1'b0;
        continue;
      end
      if (sl_cnt > 0) begin
        sl_cnt--;
        if (sl_cnt == 0) begin
          bus.SpiBusy    = 1'b0;
          bus.SpiDataOut = sl_resp;
        end
      end
      if (sl_pend) begin
        sl_pend     = 1'b0;
        bus.SpiBusy = 1'b1;
        sl_cnt      = 64 * (int'(sl_div) + 1);
      end
      if (bus.SpiStart && !stub_mode) begin
        sl_pend = 1'b1;
        sl_div  = bus.SpiClockDiv;
        sl_resp = 32'hBAD0BAD0;
        for (int i = 0; i < NREQ; i++) if (bus.Sel[i]) sl_resp = dev_resp[i];
      end
    end
  end

  // Monitor: pops an expectation at each Start, scores the Done pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        cur_valid = 1'b0;
        continue;
      end
      if (bus.SpiStart) begin
        check("start_while_busy", 32'(bus.SpiBusy), 32'd0);
        total++;
        if (cyc - start_cyc < 5) begin
          bad++;
          $display("FAIL start_spacing: got %0d cycles required >= 5", cyc - start_cyc);
        end
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
          cur_valid = 1'b0;
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
          stable_ok = 1'b1;
          check("gnt_idx", 32'(bus.GntIdx), 32'(cur.idx));
          check("sel", 32'(bus.Sel), 32'(onehot(cur.idx)));
          check("spi_data_in", bus.SpiDataIn, cur.data);
          check("spi_clock_div", 32'(bus.SpiClockDiv), 32'(cur.div));
        end
      end else if (cur_valid && bus.Done == '0) begin
        if (bus.Sel !== onehot(cur.idx) || bus.SpiDataIn !== cur.data ||
            bus.SpiClockDiv !== cur.div || !bus.ArbBusy)
          stable_ok = 1'b0;
      end
      if (bus.Done != '0) begin
        if (!cur_valid) begin
          check("unexpected_done", 32'(bus.Done), 32'd0);
        end else begin
          int lat, lo, hi;
          lat = cyc - start_cyc;
          lo  = cur.wd ? 1 : 64 * (int'(cur.div) + 1);
          hi  = cur.wd ? WD_LIMIT : 64 * (int'(cur.div) + 1) + 8;
          check("done_bit", 32'(bus.Done), 32'(onehot(cur.idx)));
          check("rd_data", bus.RdData, cur.resp);
          check("held_during_xfer", 32'(stable_ok), 32'd1);
          total++;
          if (lat < lo || lat > hi) begin
            bad++;
            $display("FAIL done_latency: got %0d cycles required %0d..%0d", lat, lo, hi);
          end
          $display("tx req=%0d data=%08h div=%0d rd=%08h lat=%0d", cur.idx, cur.data,
                   cur.div, bus.RdData, lat);
          bus.Req[cur.idx] = 1'b0;
          cur_valid        = 1'b0;
          dones++;
        end
      end
    end
  end

  task automatic rand_fill(input logic [NREQ-1:0] mask, input int div_max);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        tx_data[i]  = $urandom;
        tx_div[i]   = 8'($urandom_range(0, div_max));
        dev_resp[i] = $urandom;
      end
    end
  endtask

  // Requesters in mask are raised together while the arbiter is idle; each holds
  // until its Done, so service order is the priority order of the set.
  task automatic issue(input logic [NREQ-1:0] mask);
    int last;
    last = 0;
    for (int i = 0; i < NREQ; i++) begin
      bus.ReqData[i*32 +: 32] = tx_data[i];
      bus.ReqDiv[i*8 +: 8]    = tx_div[i];
    end
    for (int k = 0; k < NREQ; k++) begin
      int i;
      exp_t e;
      i = RR ? (m_ptr + k) % NREQ : k;
      if (mask[i]) begin
        e.idx  = i;
        e.data = tx_data[i];
        e.div  = tx_div[i];
        e.resp = stub_mode ? stub_word : dev_resp[i];
        e.wd   = stub_mode;
        exp_q.push_back(e);
        last = i;
      end
    end
    if (RR) m_ptr = (last + 1) % NREQ;
    @(negedge clk);
    #2;
    bus.Req = mask;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !cur_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("batch_complete", 32'(ok), 32'd1);
    if (!ok) begin
      exp_q.delete();
      bus.Req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, 32'(bus.Done), 32'd0);
    check({tag, "_rd_data"}, bus.RdData, 32'd0);
    check({tag, "_sel"}, 32'(bus.Sel), 32'd0);
    check({tag, "_gnt_idx"}, 32'(bus.GntIdx), 32'd0);
    check({tag, "_arb_busy"}, 32'(bus.ArbBusy), 32'd0);
    check({tag, "_clock_div"}, 32'(bus.SpiClockDiv), 32'd0);
    check({tag, "_start"}, 32'(bus.SpiStart), 32'd0);
    check({tag, "_data_in"}, bus.SpiDataIn, 32'd0);
  endtask

  initial begin
    int dones_before;
    bit seen;
    bus.Req     = '0;
    bus.ReqData = '0;
    bus.ReqDiv  = '0;
    for (int i = 0; i < NREQ; i++) begin
      tx_data[i]  = 32'h0;
      tx_div[i]   = 8'h0;
      dev_resp[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, fastest divider
    tx_data[0]  = 32'h12345678;
    tx_div[0]   = 8'd0;
    dev_resp[0] = 32'hA5A50F0F;
    issue(4'b0001);
    wait_idle();

    // Serve requester 1 alone, then 1 and 3 together
    rand_fill(4'b0010, 0);
    issue(4'b0010);
    wait_idle();
    rand_fill(4'b1010, 1);
    issue(4'b1010);
    wait_idle();

    // Divider passthrough
    rand_fill(4'b0100, 0);
    tx_div[2] = 8'd3;
    issue(4'b0100);
    wait_idle();

    // Randomised request sets
    for (int n = 0; n < 12; n++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, 15));
      rand_fill(m, 1);
      issue(m);
      wait_idle();
    end

    // Everyone requesting, two rounds
    for (int n = 0; n < 2; n++) begin
      rand_fill(4'b1111, 0);
      issue(4'b1111);
      wait_idle();
    end

    // Asynchronous reset in the middle of a transfer
    rand_fill(4'b0001, 2);
    issue(4'b0001);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.SpiBusy) begin
        seen = 1'b1;
        break;
      end
    end
    check("busy_before_reset", 32'(seen), 32'd1);
    repeat (20) @(negedge clk);
    dones_before = dones;
    #2;
    rstn    = 1'b0;
    bus.Req = '0;
    exp_q.delete();
    m_ptr = 0;
    @(negedge clk);
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_on_reset", 32'(dones), 32'(dones_before));
    check("idle_after_reset", 32'(bus.ArbBusy), 32'd0);
    rand_fill(4'b0001, 0);
    issue(4'b0001);
    wait_idle();

    // Watchdog: master never raises Busy
    stub_mode      = 1'b1;
    stub_word      = $urandom;
    bus.SpiDataOut = stub_word;
    rand_fill(4'b0100, 1);
    issue(4'b0100);
    wait_idle();
    stub_mode = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
